// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and queue entry type for the fetch stage
package fetch_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_ALIGN = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order slot array tracking allocated, filled and consumed fetches
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_inst,
  input  logic            pop,
  input  logic            flush,
  output logic [PW-1:0]   alloc_ptr,
  output logic [PW-1:0]   fill_ptr,
  output logic [PW-1:0]   head_ptr,
  output fetch_entry_t    head_entry
);

  fetch_entry_t slots [DEPTH];

  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;

  assign alloc_idx  = alloc_ptr[AW-1:0];
  assign fill_idx   = fill_ptr[AW-1:0];
  assign head_idx   = head_ptr[AW-1:0];
  assign head_entry = slots[head_idx];

  // Flush restarts the queue empty at alloc_ptr; the filled flags keep
  // stale data from ever looking valid once those slots are reused.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      fill_ptr <= alloc_ptr;
      head_ptr <= alloc_ptr;
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        slots[alloc_idx].pc     <= alloc_pc;
        slots[alloc_idx].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        slots[fill_idx].inst   <= fill_inst;
        slots[fill_idx].filled <= 1'b1;
        fill_ptr               <= fill_ptr + 1'b1;
      end
      if (pop) begin
        slots[head_idx].filled <= 1'b0;
        head_ptr               <= head_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and imem request stage; FETCH_PERF_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   drop_cnt;
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   outstanding;
  logic [PW-1:0]   used;
  logic [PW:0]     occupancy;
  fetch_entry_t    head_entry;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            inst_fire;
  logic            unused_pc_bits;

  assign outstanding = alloc_ptr - fill_ptr;
  assign used        = alloc_ptr - head_ptr;
  assign occupancy   = {1'b0, used} + {1'b0, drop_cnt};

  // Slots still owed to dropped responses count against capacity.
  assign imem_req_valid = reset && !redirect_valid && (occupancy < (PW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign rsp_fill  = imem_rsp_valid && !rsp_drop;

  assign inst_valid = head_entry.filled && (used != '0);
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign inst_fire  = inst_valid && inst_ready;

  assign unused_pc_bits = ^redirect_pc[1:0];

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .alloc      (req_fire),
    .alloc_pc   (fetch_pc),
    .fill       (rsp_fill),
    .fill_inst  (imem_rsp_data),
    .pop        (inst_fire),
    .flush      (redirect_valid),
    .alloc_ptr  (alloc_ptr),
    .fill_ptr   (fill_ptr),
    .head_ptr   (head_ptr),
    .head_entry (head_entry)
  );

  // Everything in flight at redirect becomes debt; a response landing in
  // the same cycle pays one of it back immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= drop_cnt + outstanding - PW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INST_ALIGN);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (inst_fire && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 1'b1;
    end
  end
`endif

endmodule
